// File: rtl/c3_bias_sender.sv
// c3_bias_sender
//   Transmit side of the conv-3 bias load interface. A start request in IDLE
//   reads NW consecutive words from a synchronous bias ROM, starting at the
//   captured base address, and replays them as one contiguous burst on
//   c3_bias_en/c3_bias_data. After the burst the enable is held low for a
//   fixed gap so the receiver can clear its word counter, then o_done pulses.
//
// Ports
//   i_sclk, i_rst   clock (rising edge), asynchronous active-high reset
//   i_start, i_base start request (IDLE only) and first ROM address
//   o_busy, o_done  busy level and end-of-burst pulse to the layer controller
//   o_rom_en/addr   ROM read port, i_rom_data valid one cycle after o_rom_en
//   c3_bias_en/data bias word stream to the conv-3 bias buffer
module c3_bias_sender #(
    parameter int WD = 8,
    parameter int NW = 16,
    parameter int AW = 8
) (
    input  logic          i_sclk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [AW-1:0] i_base,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_rom_en,
    output logic [AW-1:0] o_rom_addr,
    input  logic [WD-1:0] i_rom_data,
    output logic          c3_bias_en,
    output logic [WD-1:0] c3_bias_data
);

    localparam int CW = $clog2(NW + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;      // reads issued so far in this burst
    logic          wcnt_q, wcnt_d;    // cycle index inside DRAIN / GAP
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          rom_en_q, rom_en_d;
    logic [AW-1:0] addr_q, addr_d;    // doubles as the captured base
    logic          rom_en_dly_q;      // ROM data valid on i_rom_data
    logic          bias_en_q;
    logic [WD-1:0] bias_data_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wcnt_d   = wcnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        rom_en_d = 1'b0;
        addr_d   = addr_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d  = S_READ;
                    busy_d   = 1'b1;
                    rom_en_d = 1'b1;
                    addr_d   = i_base;
                    cnt_d    = CW'(1);
                end
            end
            S_READ: begin
                // cnt_q counts reads already presented; the NW-th is on the
                // port this cycle, so stop issuing after it.
                if (cnt_q == CW'(NW)) begin
                    state_d = S_DRAIN;
                    wcnt_d  = 1'b0;
                end else begin
                    rom_en_d = 1'b1;
                    addr_d   = addr_q + AW'(1);   // wraps modulo 2^AW
                    cnt_d    = cnt_q + CW'(1);
                end
            end
            S_DRAIN: begin
                // Two cycles covering ROM latency plus the output register.
                if (wcnt_q) begin
                    state_d = S_GAP;
                    wcnt_d  = 1'b0;
                end else begin
                    wcnt_d = 1'b1;
                end
            end
            S_GAP: begin
                // Enable already low; o_done lands in the second gap cycle.
                if (!wcnt_q) begin
                    done_d = 1'b1;
                    wcnt_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    wcnt_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_sclk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            wcnt_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rom_en_q     <= 1'b0;
            addr_q       <= '0;
            rom_en_dly_q <= 1'b0;
            bias_en_q    <= 1'b0;
            bias_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wcnt_q       <= wcnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rom_en_q     <= rom_en_d;
            addr_q       <= addr_d;
            rom_en_dly_q <= rom_en_q;
            bias_en_q    <= rom_en_dly_q;
            if (rom_en_dly_q)
                bias_data_q <= i_rom_data;
        end
    end

    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_rom_en     = rom_en_q;
    assign o_rom_addr   = addr_q;
    assign c3_bias_en   = bias_en_q;
    assign c3_bias_data = bias_data_q;

endmodule
